// File: rtl/vga_pkg.sv
// Shared definitions for the character bitmap writer: command field layout, glyph geometry, FSM encoding.
// Latency: none (definitions only).
// Backpressure: not applicable.
package vga_pkg;

    // Command word layout (36-bit request; unlisted bits are ignored)
    localparam int CMD_W     = 36;
    localparam int V_LSB     = 0;
    localparam int V_W       = 5;
    localparam int H_LSB     = 5;
    localparam int H_W       = 5;
    localparam int ASCII_LSB = 19;
    localparam int ASCII_W   = 8;
    localparam int CLR_BIT   = 35;

    // Glyph cell geometry
    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 8;
    localparam int ROW_W     = $clog2(CHAR_H);
    localparam int COL_SHIFT = $clog2(CHAR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Decoded command as stored in the request FIFO
    typedef struct packed {
        logic               clr;
        logic [ASCII_W-1:0] ascii;
        logic [H_W-1:0]     h_word;
        logic [V_W-1:0]     v_word;
    } char_cmd_t;

endpackage

// File: rtl/char_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH (power of two).
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: full stays high until a pop; a push while full is dropped, a pop while empty is ignored.
//
// Ports: clk, rst_n (async, active-high), push/push_data, pop/pop_data (head, valid when !empty), full, empty.
module char_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    // full is registered, so a pop in the same cycle cannot open a slot for a push
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_char_writer.sv
// Expands queued character commands into eight bitmap row writes using an external font ROM.
// Latency: first wr_en two cycles after the command is popped, then 8 consecutive writes; 10 cycles pop-to-pop.
// Backpressure: req_ready = !fifo_full (low during reset); commands wait in the FIFO while a glyph is written.
//
// Ports: clk, rst_n (async, active-high); req_valid/req_ready/req_data command input;
//        font_addr/font_data font ROM port; wr_en/wr_row/wr_col/wr_bits bitmap row write; busy.
module vga_char_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FONT_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [35:0] req_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        wr_en,
    output logic [7:0]  wr_row,
    output logic [7:0]  wr_col,
    output logic [7:0]  wr_bits,
    output logic        busy
);

    import vga_pkg::*;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHAR_H - 1);

    char_cmd_t  in_cmd;
    char_cmd_t  head_cmd;
    char_cmd_t  cmd_q;
    fsm_state_t state;
    logic [ROW_W-1:0] row;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       wr_clr;
    logic       unused_bits;

    assign in_cmd.clr    = req_data[CLR_BIT];
    assign in_cmd.ascii  = req_data[ASCII_LSB +: ASCII_W];
    assign in_cmd.h_word = req_data[H_LSB +: H_W];
    assign in_cmd.v_word = req_data[V_LSB +: V_W];

    // Reserved command bits; the ROM latency is fixed at one cycle in this revision
    assign unused_bits = ^{req_data[18:10], req_data[34:27], FONT_LAT[0]};

    assign req_ready = !rst_n && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    char_cmd_fifo #(
        .WIDTH ($bits(char_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Glyph data only arrives in the write cycle itself, so the pixel bits pass straight
    // through from the ROM, gated by the registered strobe and clear flag.
    assign wr_bits = (wr_en && !wr_clr) ? font_data : '0;

    // font_addr is loaded one edge ahead so the ROM sees row r while the FSM is on row r;
    // the matching write strobe is registered on the following edge, when the ROM data lands.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            cmd_q     <= '0;
            font_addr <= '0;
            wr_en     <= 1'b0;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_clr    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q     <= head_cmd;
                        row       <= '0;
                        font_addr <= {head_cmd.ascii, {ROW_W{1'b0}}};
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wr_en  <= 1'b1;
                    wr_row <= {cmd_q.v_word, row};
                    wr_col <= {cmd_q.h_word, {COL_SHIFT{1'b0}}};
                    wr_clr <= cmd_q.clr;
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        row       <= row + 1'b1;
                        font_addr <= {cmd_q.ascii, row + 1'b1};
                    end
                end
                ST_DRAIN: begin
                    // last row's write is on the outputs this cycle
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
